pe_feeder: RTL

//  Upstream sequencer for the parallel PE. On start, streams len 512-bit neuron chunks against
//  out_num weight rows from sync-read neuron/weight buffers, driving PE data, ctl and vld.
//  ctl[0] marks a row's first chunk (psum restart); ctl[1] marks its last chunk (result out).

---
 rtl/pe_feeder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pe_feeder.sv
// Sequencer that walks len neuron chunks against out_num weight rows in the sync-read
// buffers and presents aligned data, {last, first} control and valid to one parallel PE.
module pe_feeder #(
    parameter int DATA_W  = 512,
    parameter int NADDR_W = 8,
    parameter int WADDR_W = 12,
    parameter int LEN_W   = 8,
    parameter int NUM_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic [NUM_W-1:0]   out_num,
    output logic               busy,
    output logic               done,
    output logic               nram_rd,
    output logic [NADDR_W-1:0] nram_addr,
    input  logic [DATA_W-1:0]  nram_rdata,
    output logic               wram_rd,
    output logic [WADDR_W-1:0] wram_addr,
    input  logic [DATA_W-1:0]  wram_rdata,
    output logic [DATA_W-1:0]  pe_neuron,
    output logic [DATA_W-1:0]  pe_weight,
    output logic [1:0]         pe_ctl,
    output logic               pe_vld
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_m1_q;
    logic [NUM_W-1:0]   num_m1_q;
    logic [LEN_W-1:0]   k_p0;
    logic [NUM_W-1:0]   row_p0;
    logic [WADDR_W-1:0] wptr_p0;
    logic               rd_p0;
    logic               vld_p1;
    logic [1:0]         ctl_p1;
    logic               k_first_p0;
    logic               k_last_p0;
    logic               row_last_p0;

    assign k_first_p0  = (k_p0 == '0);
    assign k_last_p0   = (k_p0 == len_m1_q);
    assign row_last_p0 = (row_p0 == num_m1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_p0    <= 1'b0;
            k_p0     <= '0;
            row_p0   <= '0;
            wptr_p0  <= '0;
            len_m1_q <= '0;
            num_m1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // An empty job still completes with a done pulse, but never reads.
                        if (len != '0 && out_num != '0) begin
                            len_m1_q <= len - LEN_W'(1);
                            num_m1_q <= out_num - NUM_W'(1);
                            k_p0     <= '0;
                            row_p0   <= '0;
                            wptr_p0  <= '0;
                            rd_p0    <= 1'b1;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    // Weight rows are stored back to back, so one pointer covers row*len + k.
                    wptr_p0 <= wptr_p0 + WADDR_W'(1);
                    if (k_last_p0) begin
                        k_p0 <= '0;
                        if (row_last_p0) begin
                            row_p0 <= '0;
                            rd_p0  <= 1'b0;
                            state  <= DRAIN;
                        end else begin
                            row_p0 <= row_p0 + NUM_W'(1);
                        end
                    end else begin
                        k_p0 <= k_p0 + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p0 -> p1: valid and control follow the read by one cycle to line up with rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            ctl_p1 <= 2'b00;
        end else begin
            vld_p1 <= rd_p0;
            ctl_p1 <= rd_p0 ? {k_last_p0, k_first_p0} : 2'b00;
        end
    end

    assign nram_rd   = rd_p0;
    assign wram_rd   = rd_p0;
    assign nram_addr = NADDR_W'(k_p0);
    assign wram_addr = wptr_p0;
    assign pe_neuron = nram_rdata;
    assign pe_weight = wram_rdata;
    assign pe_vld    = vld_p1;
    assign pe_ctl    = ctl_p1;

endmodule
